// File: rtl/teclado_matriz_scanner.sv
// teclado_matriz_scanner: drives one active-low column at a time, samples the
// active-low rows through a 2-FF synchronizer, debounces whole scan frames and
// hands press events to the consumer through a valid/ack register.
module teclado_matriz_scanner #(
  parameter int COLS           = 4,
  parameter int ROWS           = 4,
  parameter int SETTLE         = 4,
  parameter int DEBOUNCE_SCANS = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [ROWS-1:0]               linhas,
  input  logic                          evento_ack,
  output logic [COLS-1:0]               colunas,
  output logic [COLS*ROWS-1:0]          teclas,
  output logic                          evento_valido,
  output logic [$clog2(COLS*ROWS)-1:0]  codigo_tecla,
  output logic                          multipla,
  output logic                          overrun
);

  localparam int N  = COLS * ROWS;
  localparam int KW = $clog2(N);
  localparam int SW = $clog2(SETTLE);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

  logic [ROWS-1:0] l_s1, l_s2;
  logic [SW-1:0]   s;
  logic [CW-1:0]   c;
  logic [N-1:0]    frame_buf, frame_now, prev, novos;
  logic [DW-1:0]   stable_cnt, stable_next;
  logic [KW-1:0]   low_idx;
  logic            sample, eof, accept, new_ev, multi;

  // Rows are asynchronous to clock; idle level (all released) out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      l_s1 <= '1;
      l_s2 <= '1;
    end else begin
      l_s1 <= linhas;
      l_s2 <= l_s1;
    end
  end

  // Column drive follows the scan index; released while disabled or in reset.
  assign colunas = (enable && !reset) ? ~(COLS'(1) << c) : '1;

  assign sample = enable && (s == SW'(SETTLE - 1));
  assign eof    = sample && (c == CW'(COLS - 1));

  // Frame as it stands this cycle: the active column's slice is replaced by the
  // fresh sample, so at end of frame it already includes the last column.
  for (genvar col = 0; col < COLS; col++) begin : g_slice
    assign frame_now[col*ROWS +: ROWS] =
      (sample && (c == CW'(col))) ? ~l_s2 : frame_buf[col*ROWS +: ROWS];
  end

  // Settle / column counters and the partial frame buffer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s         <= '0;
      c         <= '0;
      frame_buf <= '0;
    end else if (!enable) begin
      s         <= '0;
      c         <= '0;
      frame_buf <= '0;
    end else if (sample) begin
      s         <= '0;
      c         <= eof ? '0 : c + CW'(1);
      frame_buf <= frame_now;
    end else begin
      s <= s + SW'(1);
    end
  end

  // Consecutive-identical-frame count, saturating at DEBOUNCE_SCANS.
  always_comb begin
    stable_next = stable_cnt;
    if (frame_now != prev)
      stable_next = DW'(1);
    else if (stable_cnt < DW'(DEBOUNCE_SCANS))
      stable_next = stable_cnt + DW'(1);
  end

  assign accept = eof && (stable_next == DW'(DEBOUNCE_SCANS)) && (frame_now != teclas);
  assign novos  = frame_now & ~teclas;
  assign new_ev = accept && (|novos);
  assign multi  = |(novos & (novos - N'(1)));

  // Lowest newly pressed key wins the event code.
  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (novos[i]) low_idx = KW'(i);
  end

  // Frame debounce and accepted key state; updated only at end of frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev       <= '0;
      stable_cnt <= '0;
      teclas     <= '0;
    end else if (eof) begin
      prev       <= frame_now;
      stable_cnt <= stable_next;
      if (accept) teclas <= frame_now;
    end
  end

  // Event register: a new event replaces an acked one in the same cycle; an
  // unacked pending event is kept and the newcomer is counted as lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      evento_valido <= 1'b0;
      codigo_tecla  <= '0;
      multipla      <= 1'b0;
      overrun       <= 1'b0;
    end else if (new_ev) begin
      if (!evento_valido || evento_ack) begin
        evento_valido <= 1'b1;
        codigo_tecla  <= low_idx;
        multipla      <= multi;
      end else begin
        overrun <= 1'b1;
      end
    end else if (evento_ack) begin
      evento_valido <= 1'b0;
    end
  end

endmodule

// File: tb/tb_teclado_matriz_scanner.sv
// Bench for teclado_matriz_scanner: a key-matrix model drives linhas from
// colunas; every accept (change of teclas) is checked against a queue of
// expected snapshots pushed by the stimulus.
module tb_teclado_matriz_scanner;

  logic        clock, reset, enable, evento_ack;
  logic [3:0]  linhas, colunas;
  logic [15:0] teclas;
  logic        evento_valido, multipla, overrun;
  logic [3:0]  codigo_tecla;

  logic [15:0] keys;
  logic        rows_low;

  typedef struct packed {
    logic [15:0] teclas;
    logic        valid;
    logic [3:0]  codigo;
    logic        mult;
    logic        ovr;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  teclado_matriz_scanner #(.COLS(4), .ROWS(4), .SETTLE(4), .DEBOUNCE_SCANS(2)) dut (
    .clock(clock), .reset(reset), .enable(enable), .linhas(linhas),
    .evento_ack(evento_ack), .colunas(colunas), .teclas(teclas),
    .evento_valido(evento_valido), .codigo_tecla(codigo_tecla),
    .multipla(multipla), .overrun(overrun)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  // Pressed key shorts its column to its row.
  always_comb begin
    linhas = '1;
    if (rows_low) linhas = '0;
    else
      for (int cc = 0; cc < 4; cc++)
        for (int rr = 0; rr < 4; rr++)
          if (!colunas[cc] && keys[cc*4+rr]) linhas[rr] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, expv);
    end
  endtask

  task automatic push(input logic [15:0] t, input logic v, input logic [3:0] k,
                      input logic m, input logic o);
    exp_t e;
    e.teclas = t; e.valid = v; e.codigo = k; e.mult = m; e.ovr = o;
    sb.push_back(e);
  endtask

  // Restart the scan at a frame boundary with a new key pattern.
  task automatic align(input logic [15:0] k);
    @(negedge clock);
    enable = 1'b0;
    keys   = k;
    @(negedge clock);
    enable = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic ack_and_check();
    @(negedge clock);
    evento_ack = 1'b1;
    @(posedge clock);
    #1;
    chk("ack_clears_valid", evento_valido, 0);
    @(negedge clock);
    evento_ack = 1'b0;
  endtask

  // Monitor: every change of teclas must match the next expected snapshot.
  initial begin
    logic [15:0] last;
    exp_t e;
    last = '0;
    forever begin
      @(negedge clock);
      if (!reset && teclas !== last) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_accept got teclas=%0h want no change", teclas);
        end else begin
          e = sb.pop_front();
          chk("sb_teclas",   teclas,        e.teclas);
          chk("sb_valid",    evento_valido, e.valid);
          chk("sb_codigo",   codigo_tecla,  e.codigo);
          chk("sb_multipla", multipla,      e.mult);
          chk("sb_overrun",  overrun,       e.ovr);
        end
      end
      last = teclas;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ecol;
    reset = 1; enable = 0; evento_ack = 0; keys = '0; rows_low = 0;
    repeat (3) @(negedge clock);

    // Reset asserted mid-scan with all rows low.
    reset = 0; enable = 1; rows_low = 1;
    repeat (6) @(negedge clock);
    reset = 1;
    #1;
    chk("rst_colunas", colunas, 4'hF);
    chk("rst_teclas", teclas, 0);
    chk("rst_valid", evento_valido, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_codigo", codigo_tecla, 0);
    chk("rst_multipla", multipla, 0);
    repeat (20) @(posedge clock);
    #1;
    chk("rst_hold_colunas", colunas, 4'hF);
    chk("rst_hold_teclas", teclas, 0);
    chk("rst_hold_valid", evento_valido, 0);
    @(negedge clock);
    reset = 0; enable = 0; rows_low = 0;

    // Column sequence and enable drop.
    @(negedge clock);
    enable = 1;
    #1;
    chk("first_drive", colunas, 4'b1110);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clock);
      #1;
      ecol = ~(4'b0001 << ((k / 4) % 4));
      chk("col_seq", colunas, ecol);
    end
    repeat (6) @(posedge clock);
    @(negedge clock);
    enable = 0;
    #1;
    chk("disable_colunas", colunas, 4'hF);
    repeat (3) @(negedge clock);
    enable = 1;
    #1;
    chk("reenable_colunas", colunas, 4'b1110);
    repeat (3) @(posedge clock);
    #1;
    chk("reenable_hold", colunas, 4'b1110);
    @(posedge clock);
    #1;
    chk("reenable_next", colunas, 4'b1101);

    // Key 9 press, ack, release.
    align(16'h0200);
    push(16'h0200, 1, 4'd9, 0, 0);
    run(32);
    ack_and_check();
    align(16'h0000);
    push(16'h0000, 0, 4'd9, 0, 0);
    run(32);
    @(negedge clock);
    chk("release_teclas", teclas, 0);

    // Key 9 for a single frame only: rejected by the debounce.
    align(16'h0200);
    run(16);
    align(16'h0000);
    run(32);
    @(negedge clock);
    chk("glitch_teclas", teclas, 0);
    chk("glitch_valid", evento_valido, 0);

    // Keys 3 and 12 together.
    align(16'h1008);
    push(16'h1008, 1, 4'd3, 1, 0);
    run(32);
    ack_and_check();
    align(16'h0000);
    push(16'h0000, 0, 4'd3, 1, 0);
    run(32);

    // Key 5 left pending, then key 7 is lost.
    align(16'h0020);
    push(16'h0020, 1, 4'd5, 0, 0);
    run(32);
    align(16'h0000);
    push(16'h0000, 1, 4'd5, 0, 0);
    run(32);
    align(16'h0080);
    push(16'h0080, 1, 4'd5, 0, 1);
    run(32);

    // Same again, with ack on the accept cycle: key 7 replaces key 5.
    align(16'h0000);
    push(16'h0000, 1, 4'd5, 0, 1);
    run(32);
    align(16'h0080);
    push(16'h0080, 1, 4'd7, 0, 1);
    run(31);
    @(negedge clock);
    evento_ack = 1;
    @(posedge clock);
    @(negedge clock);
    evento_ack = 0;
    ack_and_check();
    chk("overrun_sticky", overrun, 1);

    @(negedge clock);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/teclado_matriz_scanner.md
# teclado_matriz_scanner

Scans a COLS×ROWS push-button matrix for game input, producing debounced key state and one-at-a-time press events. This is the input-side counterpart of the LED matrix driver. The block drives one active-low column at a time and samples the active-low row lines. Complete scan frames are debounced as a whole, and press events go to the game FSM through a valid/ack handshake.

## Interface
- COLS, default 4: number of matrix columns driven.
- ROWS, default 4: number of row lines sampled.
- SETTLE, default 4: clock cycles each column is held. Minimum 3, to cover the 2-FF synchronizer.
- DEBOUNCE_SCANS, default 2: number of consecutive identical frames required to accept a new state. Minimum 1.
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  runs the scan. When low, columns are released and scanning is frozen.
- linhas  in  ROWS  row inputs, active low, asynchronous to clock.
- evento_ack  in  1  consumer acknowledges the current event.
- colunas  out  COLS  column drive, active-low one-hot.
- teclas  out  COLS*ROWS  debounced key state, 1 = pressed, bit k = c*ROWS + r.
- evento_valido  out  1  a press event is pending.
- codigo_tecla  out  $clog2(COLS*ROWS)  index of the pending event's key.
- multipla  out  1  the pending event was accepted together with other newly pressed keys.
- overrun  out  1  sticky; a press event was lost.

## Operation
- **Synchronizer:** linhas passes through 2 FFs to give linhas_s.
- **Settle counter:** s runs from 0 to SETTLE-1.
- **Column index:** c runs from 0 to COLS-1. It advances when s = SETTLE-1 and wraps from COLS-1 to 0.
- **Column drive:** colunas = ~(1 << c) while enable = 1. colunas = all ones when enable = 0 or in reset.
- **Sampling:** at s = SETTLE-1, bits c*ROWS .. c*ROWS+ROWS-1 of the frame buffer are loaded with ~linhas_s.
- **End of frame:** occurs when c = COLS-1 and s = SETTLE-1. The completed frame is the buffer including the sample taken in that cycle.
  - If frame ≠ prev: stable_cnt <= 1.
  - If frame = prev: stable_cnt <= min(stable_cnt + 1, DEBOUNCE_SCANS).
  - prev <= frame in both cases.
- **Accept:** when the updated stable_cnt = DEBOUNCE_SCANS and frame ≠ teclas, then teclas <= frame (presses and releases both apply).
  - novos = frame & ~teclas.
  - If novos ≠ 0, an event is generated:
    - codigo = index of the lowest set bit of novos.
    - multipla = (popcount(novos) > 1).
  - Releases never generate events.
- **Event register:**
  - A new event is loaded when evento_valido = 0, or when evento_ack = 1 in the same cycle (ack and load together are legal; the new event wins).
  - If evento_valido = 1 and evento_ack = 0, the new event is dropped: overrun <= 1, and codigo_tecla/multipla are unchanged.
  - evento_ack with no new event clears evento_valido on the next edge.
  - evento_ack while evento_valido = 0 is ignored.
- **enable low:**
  - s and c reset to 0 and the partial frame is discarded.
  - prev, stable_cnt and teclas are held.
  - The handshake keeps working.
- **overrun** clears only on reset.

## Timing
- **Reset values:**
  - colunas = all ones.
  - teclas = 0; evento_valido = 0; codigo_tecla = 0; multipla = 0; overrun = 0.
  - s = 0, c = 0, prev = 0, stable_cnt = 0.
- **First drive:** in the first cycle with enable = 1 after reset, colunas = ~1.
- **Column period and frame:** column period = SETTLE cycles; frame = COLS*SETTLE cycles.
- **Sampling latency:** the sample uses row levels that were stable from 2 cycles before the s = SETTLE-1 edge.
- **Accept latency:** teclas and evento_valido update on the edge that ends the DEBOUNCE_SCANS-th consecutive identical frame. Both change on the same edge.
- **Ack timing:** evento_valido falls on the edge after evento_ack is sampled high.
- **Reset mid-frame:** the frame is aborted and everything returns to reset values immediately (asynchronous).

## Test plan
All scenarios use COLS=4, ROWS=4, SETTLE=4, DEBOUNCE_SCANS=2, so a frame is 16 cycles.
- Reset asserted mid-scan with linhas=0 -> colunas=1111, teclas=0, evento_valido=0, overrun=0, all held while reset stays high.
- enable=1, linhas=1111 -> colunas 1110 (4 cycles), 1101, 1011, 0111, then 1110 again at cycle 16. Drop enable at cycle 6 -> colunas=1111; re-enable -> restarts at 1110.
- Row 1 held low only while column 2 is active (key 9), from before frame start -> at the end of the 2nd frame: teclas=0x0200, evento_valido=1, codigo_tecla=9, multipla=0. Ack -> evento_valido=0 next cycle. Release -> teclas=0 two frames later with no event.
- Key 9 pressed for exactly one frame, then released -> no event, teclas stays 0.
- Keys 3 and 12 pressed in the same frame -> one event with codigo_tecla=3, multipla=1, teclas=0x1008.
- Key 5 accepted and not acked; release, then press key 7 -> at key 7's accept: overrun=1, codigo_tecla stays 5, teclas=0x0080. Repeat with ack asserted on the accept cycle -> codigo_tecla=7 and overrun unchanged.
